// File: rtl/fifo_arb_pkg.sv
// Shared sizing and op encoding for the four-channel FIFO write arbiter.
package fifo_arb_pkg;

    localparam int N_REQ = 4;
    localparam int DEPTH = 8;
    localparam int W     = 8;
    localparam int IDX_W = 2;
    localparam int PTR_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // One issued FIFO operation, as decided at the arbitration edge.
    typedef struct packed {
        logic             wr;
        logic             rd;
        logic [IDX_W-1:0] ch;
    } issue_t;

endpackage

// File: rtl/fifo_wr_arbiter_4_rr_pick4.sv
// Combinational round-robin pick: first requester at or after rr, searching upward mod 4.
module rr_pick4
    import fifo_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        j   = '0;
        idx = rr;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = rr + IDX_W'(i);
            if (req[j]) begin
                idx = j;
                any = 1'b1;
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter_4.sv
// Shares one 8x8 FIFO between four producers and one consumer; tracks occupancy
// and remembers which channel wrote each stored byte.
module fifo_wr_arbiter_4
    import fifo_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    output logic [N_REQ-1:0]   gnt,
    input  logic               rd_req,
    output logic               rd_valid,
    output logic [W-1:0]       rd_data,
    output logic [IDX_W-1:0]   rd_src,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output logic               err,
    output logic               fifo_wen,
    output logic               fifo_ren,
    output logic [W-1:0]       fifo_din,
    input  logic [W-1:0]       fifo_dout,
    input  logic               fifo_error
);

    logic [IDX_W-1:0] rr;
    op_e              last_op;
    logic [IDX_W-1:0] tag_q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [IDX_W-1:0] pend_src;

    logic [N_REQ-1:0] req_elig;
    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             wr_elig;
    logic             rd_elig;
    issue_t           iss;

    // A channel whose grant is still showing has already been served.
    assign req_elig = req & ~gnt;

    rr_pick4 u_pick (
        .req (req_elig),
        .rr  (rr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign wr_elig = pick_any && (count < CNT_W'(DEPTH));
    assign rd_elig = rd_req && (count != '0);

    // When both are eligible, take the opposite of the previous op.
    always_comb begin
        iss.wr = wr_elig && (!rd_elig || last_op == OP_READ);
        iss.rd = rd_elig && (!wr_elig || last_op == OP_WRITE);
        iss.ch = pick_idx;
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            fifo_wen <= 1'b0;
            fifo_ren <= 1'b0;
            fifo_din <= '0;
            rd_valid <= 1'b0;
            rd_src   <= '0;
            count    <= '0;
            err      <= 1'b0;
            rr       <= '0;
            last_op  <= OP_READ;
            head     <= '0;
            tail     <= '0;
            pend_src <= '0;
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
        end else begin
            gnt      <= '0;
            fifo_wen <= 1'b0;
            fifo_ren <= 1'b0;
            // Read response lines up with the FIFO's registered dout.
            rd_valid <= fifo_ren;
            rd_src   <= pend_src;
            err      <= err | fifo_error;
            if (iss.wr) begin
                gnt         <= pick_gnt;
                fifo_wen    <= 1'b1;
                fifo_din    <= din[iss.ch*W +: W];
                rr          <= iss.ch + 1'b1;
                count       <= count + 1'b1;
                tag_q[tail] <= iss.ch;
                tail        <= tail + 1'b1;
                last_op     <= OP_WRITE;
            end else if (iss.rd) begin
                fifo_ren <= 1'b1;
                count    <= count - 1'b1;
                pend_src <= tag_q[head];
                head     <= head + 1'b1;
                last_op  <= OP_READ;
            end
        end
    end

endmodule
